// File: rtl/vu_pkg.sv
// Shared constants and FSM encoding for the VU-meter level detector.
// Timer defaults are derived from the system clock frequency.
package vu_pkg;

  localparam int CLK_HZ                 = 50_000_000;
  localparam int LEDS_DEFAULT           = 20;
  localparam int DECAY_STEP_DEFAULT     = 16;
  localparam int DECAY_DIV_DEFAULT      = CLK_HZ / 1000;  // 1 ms decay tick
  localparam int REFRESH_CYCLES_DEFAULT = CLK_HZ / 50;    // 20 ms refresh

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } vu_state_e;

endpackage

// File: rtl/vu_peak_hold.sv
// Full-wave rectifier plus peak register with linear, saturating decay.
// A sample arriving on a decay tick is compared against the decayed peak.
module vu_peak_hold
  import vu_pkg::*;
#(
  parameter int SAMPLE_W   = 12,
  parameter int DECAY_DIV  = 50_000,
  parameter int DECAY_STEP = DECAY_STEP_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  output logic [SAMPLE_W-1:0] o_peak
);

  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [SAMPLE_W-1:0] STEP = SAMPLE_W'(DECAY_STEP);

  logic [DW-1:0]       decay_cnt_q, decay_cnt_d;
  logic                decay_tick;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [SAMPLE_W-1:0] abs_sample;
  logic [SAMPLE_W-1:0] decayed;

  // Negating in SAMPLE_W bits maps the most negative code onto 2^(SAMPLE_W-1) unsigned.
  assign abs_sample = i_sample[SAMPLE_W-1] ? (SAMPLE_W'(0) - i_sample) : i_sample;

  assign decay_tick = (decay_cnt_q == DW'(DECAY_DIV - 1));

  always_comb begin
    decay_cnt_d = decay_tick ? '0 : decay_cnt_q + DW'(1);
  end

  always_comb begin
    decayed = peak_q;
    if (decay_tick) begin
      decayed = (peak_q > STEP) ? (peak_q - STEP) : '0;
    end
    peak_d = decayed;
    if (i_sample_valid && (abs_sample > decayed)) begin
      peak_d = abs_sample;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      decay_cnt_q <= '0;
      peak_q      <= '0;
    end else begin
      decay_cnt_q <= decay_cnt_d;
      peak_q      <= peak_d;
    end
  end

  assign o_peak = peak_q;

endmodule

// File: rtl/vu_level_detector.sv
// Maps the held audio peak to a 0..LEDS bar length and hands it to the pixel
// controller once per refresh period, only when the bar length has changed.
module vu_level_detector
  import vu_pkg::*;
#(
  parameter int SAMPLE_W       = 12,
  parameter int LEDS           = LEDS_DEFAULT,
  parameter int DECAY_DIV      = DECAY_DIV_DEFAULT,
  parameter int DECAY_STEP     = DECAY_STEP_DEFAULT,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  input  logic                i_rdy,
  output logic [7:0]          o_value,
  output logic                o_send
);

  localparam int PW = SAMPLE_W + $clog2(LEDS + 1);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [SAMPLE_W-1:0] peak;
  logic [PW-1:0]       product;
  logic [PW-1:0]       scaled;
  logic [7:0]          level_q, level_d;

  logic [RW-1:0]       refresh_cnt_q, refresh_cnt_d;
  logic                wrap_q, wrap_d;
  logic                pending_q, pending_d;

  vu_state_e           state_q, state_d;
  logic [7:0]          last_sent_q, last_sent_d;
  logic [7:0]          value_q, value_d;
  logic                send_q, send_d;

  vu_peak_hold #(
    .SAMPLE_W   (SAMPLE_W),
    .DECAY_DIV  (DECAY_DIV),
    .DECAY_STEP (DECAY_STEP)
  ) u_peak_hold (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_peak         (peak)
  );

  // Full scale is 2^(SAMPLE_W-1); a larger rectified peak overshoots and is clamped.
  always_comb begin
    product = PW'(peak) * PW'(LEDS);
    scaled  = product >> (SAMPLE_W - 1);
    level_d = (scaled > PW'(LEDS)) ? 8'(LEDS) : 8'(scaled);
  end

  always_comb begin
    wrap_d        = (refresh_cnt_q == RW'(REFRESH_CYCLES - 1));
    refresh_cnt_d = wrap_d ? '0 : refresh_cnt_q + RW'(1);
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    last_sent_d = last_sent_q;
    value_d     = value_q;
    send_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q && i_rdy) begin
          pending_d = 1'b0;
          if (level_q != last_sent_q) begin
            value_d     = level_q;
            last_sent_d = level_q;
            send_d      = 1'b1;
            state_d     = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (!i_rdy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh refresh request wins over the clear of an older one.
    if (wrap_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_q       <= '0;
      refresh_cnt_q <= '0;
      wrap_q        <= 1'b0;
      pending_q     <= 1'b0;
      state_q       <= IDLE;
      last_sent_q   <= 8'hFF;
      value_q       <= '0;
      send_q        <= 1'b0;
    end else begin
      level_q       <= level_d;
      refresh_cnt_q <= refresh_cnt_d;
      wrap_q        <= wrap_d;
      pending_q     <= pending_d;
      state_q       <= state_d;
      last_sent_q   <= last_sent_d;
      value_q       <= value_d;
      send_q        <= send_d;
    end
  end

  assign o_value = value_q;
  assign o_send  = send_q;

endmodule

// File: tb/tb_vu_level_detector.sv
// Self-checking bench for vu_level_detector: directed scenarios plus a
// randomized run, all checked against an arithmetic model of peak and level.
module tb_vu_level_detector;
  import vu_pkg::*;

  localparam int SW      = 12;
  localparam int NLEDS   = 20;
  localparam int DDIV    = 10;
  localparam int DSTEP   = 64;
  localparam int REFRESH = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] sample = '0;
  logic          valid = 1'b0;
  logic          rdy = 1'b1;
  logic [7:0]    o_value;
  logic          o_send;

  int n_checks = 0;
  int n_fail   = 0;

  vu_level_detector #(
    .SAMPLE_W       (SW),
    .LEDS           (NLEDS),
    .DECAY_DIV      (DDIV),
    .DECAY_STEP     (DSTEP),
    .REFRESH_CYCLES (REFRESH)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample       (sample),
    .i_sample_valid (valid),
    .i_rdy          (rdy),
    .o_value        (o_value),
    .o_send         (o_send)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int absv(logic [SW-1:0] s);
    if (s[SW-1]) return (1 << SW) - int'(s);
    return int'(s);
  endfunction

  function automatic int next_peak(int p, bit tick, logic v, logic [SW-1:0] s);
    int d;
    d = p;
    if (tick) begin
      d = p - DSTEP;
      if (d < 0) d = 0;
    end
    if (v && absv(s) > d) d = absv(s);
    return d;
  endfunction

  function automatic int lvl(int p);
    int l;
    l = (p * NLEDS) / (1 << (SW - 1));
    return (l > NLEDS) ? NLEDS : l;
  endfunction

  int m_cyc = 0;      // non-reset edges since reset
  int m_peak = 0;
  int m_peak_d1 = 0;
  int m_peak_d2 = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc     <= 0;
      m_peak    <= 0;
      m_peak_d1 <= 0;
      m_peak_d2 <= 0;
    end else begin
      m_cyc     <= m_cyc + 1;
      m_peak    <= next_peak(m_peak, (m_cyc % DDIV) == DDIV - 1, valid, sample);
      m_peak_d1 <= m_peak;
      m_peak_d2 <= m_peak_d1;
    end
  end

  // ---------------- continuous monitor ----------------
  int   m_last = 255;
  int   m_held = 0;
  logic prev_send = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_last    <= 255;
      m_held    <= 0;
      prev_send <= 1'b0;
    end else begin
      check_value("peak", int'(dut.peak), m_peak);
      check_value("level", int'(dut.level_q), lvl(m_peak_d1));
      if (o_send) begin
        check_value("send_val", int'(o_value), lvl(m_peak_d2));
        check_value("send_changed", int'(int'(o_value) != m_last), 1);
        check_value("no_b2b", int'(prev_send), 0);
        $display("send: cyc=%0d value=%0d", m_cyc, o_value);
        m_last <= int'(o_value);
        m_held <= int'(o_value);
      end else begin
        check_value("hold", int'(o_value), m_held);
      end
      prev_send <= o_send;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit auto_ack = 1'b0;
  int hold_c = 0;
  int busy_c = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      if (o_send) begin
        hold_c = $urandom_range(0, 3);
        busy_c = $urandom_range(1, 20);
        if (hold_c == 0) rdy = 1'b0;
      end else if (hold_c > 0) begin
        hold_c--;
        if (hold_c == 0) rdy = 1'b0;
      end else if (!rdy && busy_c > 0) begin
        busy_c--;
        if (busy_c == 0) rdy = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    sample = '0;
    hold_c = 0;
    busy_c = 0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (m_cyc < n) step();
  endtask

  task automatic wait_send(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (o_send) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_until(input int n, output int c);
    c = 0;
    while (m_cyc < n) begin
      step();
      if (o_send) c++;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit got;
    int c;
    int rand_sends;

    // Reset state
    do_reset();
    check_value("rst_send", int'(o_send), 0);
    check_value("rst_value", int'(o_value), 0);
    check_value("rst_peak", int'(dut.peak), 0);
    check_value("rst_level", int'(dut.level_q), 0);
    check_value("rst_last_sent", int'(dut.last_sent_q), 255);
    check_value("rst_state", int'(dut.state_q), int'(IDLE));
    check_value("rst_pending", int'(dut.pending_q), 0);
    check_value("rst_refresh_cnt", int'(dut.refresh_cnt_q), 0);
    check_value("rst_decay_cnt", int'(dut.u_peak_hold.decay_cnt_q), 0);

    // First refresh sends 0, second refresh sends nothing
    auto_ack = 1'b1;
    rdy = 1'b1;
    wait_send(150, got);
    check_value("first_send_seen", int'(got), 1);
    check_value("first_send_cyc", m_cyc, 2 * 1 + REFRESH);
    check_value("first_send_val", int'(o_value), 0);
    step();
    check_value("send_one_cycle", int'(o_send), 0);
    count_until(260, c);
    check_value("second_refresh_nosend", c, 0);

    // Sample -2048 just before the refresh gives a full bar
    auto_ack = 1'b0;
    rdy = 1'b1;
    do_reset();
    wait_cyc(REFRESH - 1);
    sample = 12'h800;
    valid = 1'b1;
    step();
    valid = 1'b0;
    wait_send(10, got);
    check_value("neg_full_seen", int'(got), 1);
    check_value("neg_full_val", int'(o_value), 20);

    // Sample +1024 gives half a bar
    do_reset();
    wait_cyc(REFRESH - 1);
    sample = 12'd1024;
    valid = 1'b1;
    step();
    valid = 1'b0;
    wait_send(10, got);
    check_value("half_seen", int'(got), 1);
    check_value("half_val", int'(o_value), 10);

    // Decay of 200: 136, 72, 8, 0, 0
    do_reset();
    sample = 12'd200;
    valid = 1'b1;
    step();
    valid = 1'b0;
    check_value("decay_p0", int'(dut.peak), 200);
    wait_cyc(10); check_value("decay_p1", int'(dut.peak), 136);
    wait_cyc(20); check_value("decay_p2", int'(dut.peak), 72);
    wait_cyc(30); check_value("decay_p3", int'(dut.peak), 8);
    wait_cyc(40); check_value("decay_p4", int'(dut.peak), 0);
    wait_cyc(50); check_value("decay_p5", int'(dut.peak), 0);

    // i_rdy low across three wraps: one coalesced send once it rises
    rdy = 1'b0;
    do_reset();
    count_until(350, c);
    check_value("rdy_low_nosend", c, 0);
    rdy = 1'b1;
    wait_send(4, got);
    check_value("coalesced_seen", int'(got), 1);
    check_value("coalesced_latency_ok", int'(m_cyc >= 351 && m_cyc <= 352), 1);
    count_until(450, c);
    check_value("coalesced_single", c, 0);

    // Send, rdy high 3 cycles, low 250, then high: pending refresh sends once
    rdy = 1'b1;
    do_reset();
    wait_send(150, got);
    check_value("busy_first_seen", int'(got), 1);
    wait_cyc(105);
    rdy = 1'b0;
    count_until(340, c);
    sample = 12'd2047;
    valid = 1'b1;
    step();
    valid = 1'b0;
    if (o_send) c++;
    begin
      int c2;
      count_until(355, c2);
      check_value("busy_nosend", c + c2, 0);
    end
    rdy = 1'b1;
    wait_send(6, got);
    check_value("busy_release_seen", int'(got), 1);
    check_value("busy_release_val", int'(o_value), 19);
    count_until(380, c);
    check_value("busy_release_single", c, 0);

    // Reset pulsed in WAIT_DONE with the level held at full scale
    rdy = 1'b1;
    do_reset();
    sample = 12'h800;
    valid = 1'b1;
    wait_send(150, got);
    check_value("wd_first_seen", int'(got), 1);
    check_value("wd_first_val", int'(o_value), 20);
    step();
    rdy = 1'b0;
    count_until(150, c);
    check_value("wd_state", int'(dut.state_q), int'(WAIT_DONE));
    rst = 1'b1;
    step();
    check_value("wd_rst_state", int'(dut.state_q), int'(IDLE));
    check_value("wd_rst_send", int'(o_send), 0);
    check_value("wd_rst_value", int'(o_value), 0);
    check_value("wd_rst_last_sent", int'(dut.last_sent_q), 255);
    rst = 1'b0;
    rdy = 1'b1;
    wait_send(150, got);
    check_value("wd_resend_seen", int'(got), 1);
    check_value("wd_resend_cyc", m_cyc, REFRESH + 2);
    check_value("wd_resend_val", int'(o_value), 20);
    valid = 1'b0;

    // Randomized run with a responding pixel controller
    do_reset();
    auto_ack = 1'b1;
    rdy = 1'b1;
    rand_sends = 0;
    for (int seg = 0; seg < 40; seg++) begin
      int amp;
      amp = $urandom_range(0, 11);
      for (int i = 0; i < 150; i++) begin
        int mag;
        mag = $urandom_range(0, 1 << amp);
        sample = ($urandom_range(0, 1) == 1) ? SW'(-mag) : SW'(mag);
        valid = ($urandom_range(0, 7) == 0);
        step();
        if (o_send) rand_sends++;
      end
    end
    valid = 1'b0;
    check_value("rand_sends_nonzero", int'(rand_sends > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vu_level_detector.md
# vu_level_detector

Upstream stage of `npxl_controller` in the VU-meter datapath. Takes a stream of signed audio samples and full-wave rectifies them. Keeps a peak value that holds new maxima and decays linearly, and maps that peak to a bar length of 0..LEDS. At a fixed refresh rate it hands the bar length to `npxl_controller` through that block's `i_value`/`i_send`/`o_rdy` handshake.

## Interface
- SAMPLE_W, 12: sample width, two's complement
- LEDS, 20: LED count of the strip; must be ≤ 255; must match `npxl_controller`
- DECAY_DIV, 50000: clock cycles per decay tick (1 ms at 50 MHz)
- DECAY_STEP, 16: amount subtracted from the peak per decay tick
- REFRESH_CYCLES, 1000000: clock cycles per display refresh (20 ms at 50 MHz)
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_sample  in  SAMPLE_W  signed audio sample
- i_sample_valid  in  1  qualifies i_sample for one cycle
- i_rdy  in  1  connect to `npxl_controller.o_rdy`
- o_value  out  8  bar length 0..LEDS; connect to `i_value`
- o_send  out  1  one-cycle send strobe; connect to `i_send`

## Operation
- Rectify: abs = |i_sample| as SAMPLE_W-bit unsigned, so −2^(SAMPLE_W−1) gives 2^(SAMPLE_W−1) with no overflow.
- Peak register (SAMPLE_W bits, unsigned), next value:
  - d = peak − DECAY_STEP on a decay tick, saturating at 0; otherwise d = peak.
  - If i_sample_valid: peak ← max(abs, d); else peak ← d.
  - A sample and a decay tick in the same cycle are both applied; the sample is compared against the decayed value.
- Level register: level = (peak × LEDS) >> (SAMPLE_W−1), clamped to LEDS.
  - Product width: SAMPLE_W + clog2(LEDS+1).
  - Registered one cycle after the peak.
- Refresh timer: counts 0..REFRESH_CYCLES−1 and wraps. On wrap it sets `pending`. Repeated wraps while `pending` is already set coalesce into a single request.
- last_sent register: 8 bits, reset value 8'hFF, so the first refresh after reset always sends.
- FSM:
  - IDLE: if pending and i_rdy:
    - level ≠ last_sent: o_value ← level, last_sent ← level, o_send ← 1, clear pending, go to WAIT_ACK.
    - level = last_sent: clear pending, no send, stay in IDLE.
  - IDLE: if pending and not i_rdy, hold pending.
  - WAIT_ACK: o_send ← 0. When i_rdy = 0, go to WAIT_DONE.
  - WAIT_DONE: when i_rdy = 1, go to IDLE.
- o_value holds its value from the send until the next send.

## Timing
- Reset values: o_send 0, o_value 0, peak 0, level 0, last_sent 8'hFF, both timers 0, pending 0, state IDLE.
- A sample valid at edge N updates the peak at N+1 and the level at N+2.
- The refresh wrap at edge T sets pending at T+1. With i_rdy high in IDLE, o_send and o_value are driven together at T+2.
- o_send is registered and high for exactly one cycle. Back-to-back sends are impossible.
- i_rdy may fall on the cycle right after o_send or later; WAIT_ACK waits indefinitely for it.
- Reset asserted mid-operation returns every register to its reset value on the next edge, and o_send drops immediately.

## Structure
- Shared package `vu_pkg`:
  - LEDS default
  - clock frequency constant, used to derive DECAY_DIV and REFRESH_CYCLES
  - FSM state encoding: IDLE, WAIT_ACK, WAIT_DONE
- One natural sub-module, `vu_peak_hold`: rectifier, decay timer and peak register. The level mapping, refresh timer and FSM stay at top level.

## Test plan
Bench parameters: SAMPLE_W=12, LEDS=20, DECAY_DIV=10, DECAY_STEP=64, REFRESH_CYCLES=100; the bench models i_rdy.
- Reset released, i_rdy=1, no samples -> first refresh sends o_value=0 with a one-cycle o_send; the second refresh produces no send.
- Single sample −2048 -> level 20 and o_value=20 at the next refresh. After reset, single sample +1024 -> o_value=10.
- Sample 200 followed by silence -> peak goes 136, 72, 8, 0 on successive decay ticks and stays at 0 (no wrap).
- i_rdy held low across three refresh wraps, then raised -> exactly one o_send, two cycles after i_rdy rises.
- After a send, i_rdy stays high 3 cycles, low 250 cycles, then high -> no o_send until the return to IDLE; the pending refresh then sends once.
- i_rst pulsed during WAIT_DONE with the level unchanged -> state IDLE, o_send 0, o_value 0; the next refresh sends again because last_sent was reset to 8'hFF.
